// File: rtl/iic_pkg.sv
// Shared constants for the I2C EEPROM target: FSM state encodings, the default
// device address and the bus-level meaning of ACK/NACK.
package iic_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEV_ADDR  = 4'd1;
    localparam logic [3:0] ST_DEV_ACK   = 4'd2;
    localparam logic [3:0] ST_WORD_ADDR = 4'd3;
    localparam logic [3:0] ST_WORD_ACK  = 4'd4;
    localparam logic [3:0] ST_WR_DATA   = 4'd5;
    localparam logic [3:0] ST_WR_ACK    = 4'd6;
    localparam logic [3:0] ST_RD_DATA   = 4'd7;
    localparam logic [3:0] ST_RD_ACK    = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b1010000;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/iic_line_sync.sv
// Conditions one raw I2C pad line: 2-FF synchroniser, optional 3-sample majority
// filter (IIC_SLAVE_GLITCH_FILTER_EN), and single-cycle rise/fall pulses.
module iic_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       filt;
    logic       prev;

    // Everything resets to the bus idle level (high) so that leaving reset on
    // an idle bus produces no spurious edge.
    // NOTE: sequential state uses non-blocking assignments only; blocking ones
    // here would let a register see its neighbour's new value in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], raw};
        end
    end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
            filt <= 1'b1;
        end else begin
            hist <= {hist[0], sync[1]};
            filt <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
        end
    end
`else
    assign filt = sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= filt;
        end
    end

    assign level = filt;
    assign rise  = filt & ~prev;
    assign fall  = ~filt & prev;

endmodule

// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 24C02-style EEPROM: address/word ACK, page writes with
// in-page pointer wrap, and sequential reads. Glitch filter: IIC_SLAVE_GLITCH_FILTER_EN.
module iic_eeprom_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int         MEM_AW   = 8,
    parameter int         PAGE_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_strobe,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              selected
);

    localparam int              DEPTH     = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((1 << PAGE_W) - 1);
    localparam logic [MEM_AW-1:0] PTR_ONE   = MEM_AW'(1);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    iic_line_sync u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (scl_i),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    iic_line_sync u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .raw   (sda_i),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic              start_cond, stop_cond;
    logic [3:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        shift_in;
    logic [MEM_AW-1:0] ptr;
    logic [MEM_AW-1:0] ptr_page_next;
    logic              rw;
    logic              drv_pend;
    logic              mem_we;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_q;

    assign start_cond    = sda_fall & scl;
    assign stop_cond     = sda_rise & scl;
    assign shift_in      = {shreg[6:0], sda};
    assign ptr_page_next = (ptr & ~PAGE_MASK) | ((ptr + PTR_ONE) & PAGE_MASK);
    assign mem_we        = (state == ST_WR_DATA) && scl_rise && (bit_cnt == 4'd7)
                           && !start_cond && !stop_cond;

    // NOTE: the byte array has no reset; clearing it would turn the RAM into
    // flops. Contents are defined only after they are written over the bus.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= shift_in;
        end
        rd_q <= mem[ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            ptr       <= '0;
            rw        <= 1'b0;
            drv_pend  <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
            selected  <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_cond) begin
                state    <= ST_DEV_ADDR;
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                drv_pend <= 1'b0;
                selected <= 1'b0;
            end else if (stop_cond) begin
                state    <= ST_IDLE;
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                drv_pend <= 1'b0;
                selected <= 1'b0;
            end else begin
                case (state)
                    ST_DEV_ADDR: begin
                        if (scl_rise) begin
                            shreg <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                rw      <= sda;
                                state   <= (shift_in[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // bit_cnt 0: first fall starts the ACK bit; 1: ninth fall ends it.
                    ST_DEV_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe   <= ~ACK;
                                selected <= 1'b1;
                                bit_cnt  <= 4'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                if (rw) begin
                                    shreg    <= rd_q;
                                    drv_pend <= 1'b1;
                                    state    <= ST_RD_DATA;
                                end else begin
                                    state <= ST_WORD_ADDR;
                                end
                            end
                        end
                    end

                    ST_WORD_ADDR: begin
                        if (scl_rise) begin
                            shreg <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                ptr     <= MEM_AW'(shift_in);
                                state   <= ST_WORD_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_WORD_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe  <= ~ACK;
                                bit_cnt <= 4'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_WR_DATA;
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= 4'd0;
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= shift_in;
                                ptr       <= ptr_page_next;
                                state     <= ST_WR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // The next bit goes out one cycle after each SCL fall, which also
                    // covers the one-cycle memory read latency on the first bit.
                    ST_RD_DATA: begin
                        if (drv_pend) begin
                            sda_oe   <= ~shreg[7];
                            drv_pend <= 1'b0;
                        end
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_RD_ACK;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b0};
                                drv_pend <= 1'b1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda == NACK) begin
                                state <= ST_IGNORE;
                            end else begin
                                ptr     <= ptr + PTR_ONE;
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            shreg    <= rd_q;
                            drv_pend <= 1'b1;
                            bit_cnt  <= 4'd0;
                            state    <= ST_RD_DATA;
                        end
                    end

                    ST_IDLE, ST_IGNORE: begin
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: a bit-banged I2C master drives the pads
// and every ACK, read byte and committed write is compared with fixed expectations.
module tb_iic_eeprom_slave;

    localparam int Q = 6;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe, wr_strobe, selected;
    logic [7:0] wr_addr, wr_data;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    iic_eeprom_slave dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .selected  (selected)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] st_addr[$];
    logic [7:0] st_data[$];

    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            st_addr.push_back(wr_addr);
            st_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        if (glitch) begin
            m_scl = 1'b0; @(negedge clk);
            m_scl = 1'b1;
        end
        wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = sda_i;    wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack_bit, 1'b0);
    endtask

    task automatic check_writes(input string tag, input int base, input int n,
                                input logic [7:0] ea [3], input logic [7:0] ed [3]);
        check({tag, "_count"}, st_addr.size(), base + n);
        for (int k = 0; k < n; k++) begin
            if (base + k < st_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, k), st_addr[base + k], ea[k]);
                check($sformatf("%s_data%0d", tag, k), st_data[base + k], ed[k]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        int         base;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_selected", selected, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Page write of three bytes at 0x10
        base = st_addr.size();
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t1_dev_ack", ack, 0);
        check("t1_selected", selected, 1);
        send_byte(8'h10, -1, ack); check("t1_word_ack", ack, 0);
        send_byte(8'h11, -1, ack); check("t1_d0_ack", ack, 0);
        send_byte(8'h22, -1, ack); check("t1_d1_ack", ack, 0);
        send_byte(8'h33, -1, ack); check("t1_d2_ack", ack, 0);
        i2c_stop();
        ea = '{8'h10, 8'h11, 8'h12}; ed = '{8'h11, 8'h22, 8'h33};
        check_writes("t1", base, 3, ea, ed);

        // Page wrap: 0x06, 0x07, then back to 0x00
        base = st_addr.size();
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t2_dev_ack", ack, 0);
        send_byte(8'h06, -1, ack); check("t2_word_ack", ack, 0);
        send_byte(8'hAA, -1, ack);
        send_byte(8'hBB, -1, ack);
        send_byte(8'hCC, -1, ack); check("t2_d2_ack", ack, 0);
        i2c_stop();
        ea = '{8'h06, 8'h07, 8'h00}; ed = '{8'hAA, 8'hBB, 8'hCC};
        check_writes("t2", base, 3, ea, ed);
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h00, -1, ack);
        i2c_start();
        send_byte(8'hA1, -1, ack); check("t2_rd_ack", ack, 0);
        recv_byte(1'b1, d); check("t2_rd_0x00", d, 8'hCC);
        i2c_stop();

        // Random read of three bytes from 0x10
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h10, -1, ack); check("t3_word_ack", ack, 0);
        i2c_start();
        send_byte(8'hA1, -1, ack); check("t3_rd_ack", ack, 0);
        recv_byte(1'b0, d); check("t3_rd0", d, 8'h11);
        recv_byte(1'b0, d); check("t3_rd1", d, 8'h22);
        recv_byte(1'b1, d); check("t3_rd2", d, 8'h33);
        check("t3_sda_released", sda_oe, 0);
        check("t3_selected_hold", selected, 1);
        i2c_stop();
        check("t3_selected_stop", selected, 0);

        // Wrong device address
        base = st_addr.size();
        i2c_start();
        send_byte(8'hA2, -1, ack); check("t4_dev_nack", ack, 1);
        check("t4_selected", selected, 0);
        send_byte(8'h55, -1, ack); check("t4_ignore_nack", ack, 1);
        i2c_stop();
        check("t4_no_write", st_addr.size(), base);

        // STOP after 5 bits of a data byte
        base = st_addr.size();
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h20, -1, ack); check("t5_word_ack", ack, 0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("t5_no_write", st_addr.size(), base);
        check("t5_selected", selected, 0);

        // Reset mid-read while the target pulls SDA (MSB of 0x11 is 0)
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h10, -1, ack);
        i2c_start();
        send_byte(8'hA1, -1, ack);
        repeat (2) @(negedge clk);
        check("t6_sda_driven", sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_sda_after_rst", sda_oe, 0);
        check("t6_selected_after_rst", selected, 0);
        rst = 1'b0;
        i2c_stop();

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
        // 1-clk SCL glitch during a data byte must not shift an extra bit
        base = st_addr.size();
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h30, -1, ack);
        send_byte(8'h5A, 3, ack); check("t7_data_ack", ack, 0);
        i2c_stop();
        ea = '{8'h30, 8'h00, 8'h00}; ed = '{8'h5A, 8'h00, 8'h00};
        check_writes("t7", base, 1, ea, ed);
`endif

        // Fresh write after all of the above still works from IDLE
        base = st_addr.size();
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t8_dev_ack", ack, 0);
        send_byte(8'hFF, -1, ack);
        send_byte(8'h3C, -1, ack); check("t8_d0_ack", ack, 0);
        i2c_stop();
        ea = '{8'hFF, 8'h00, 8'h00}; ed = '{8'h3C, 8'h00, 8'h00};
        check_writes("t8", base, 1, ea, ed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
